// File: rtl/axi_arbiter_w.sv
// Round-robin write-channel arbiter for the two-master AXI interconnect; holds a grant across AW, W..WLAST and B.
// Optional AW-handshake timeout is compiled in with `define AXI_ARB_W_TIMEOUT_EN.
module axi_arbiter_w #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic m0_AWVALID,
  input  logic m1_AWVALID,
  input  logic s_AWVALID,
  input  logic s_WVALID,
  input  logic s_WLAST,
  input  logic s_BREADY,
  input  logic m_AWREADY,
  input  logic m_WREADY,
  input  logic m_BVALID,
  output logic m0_wgrnt,
  output logic m1_wgrnt,
  output logic w_busy,
  output logic w_owner
`ifdef AXI_ARB_W_TIMEOUT_EN
  ,
  output logic w_timeout
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t state, state_n;
  logic   owner_n;
  logic   aw_done, aw_done_n;
  logic   w_done, w_done_n;
  logic   aw_hs, wl_hs, b_hs;

`ifdef AXI_ARB_W_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          tmo_n;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign aw_hs = s_AWVALID & m_AWREADY;
  assign wl_hs = s_WVALID & m_WREADY & s_WLAST;
  assign b_hs  = m_BVALID & s_BREADY;

  always_comb begin
    state_n   = state;
    owner_n   = w_owner;
    aw_done_n = aw_done;
    w_done_n  = w_done;
`ifdef AXI_ARB_W_TIMEOUT_EN
    cnt_n = cnt;
    tmo_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (m0_AWVALID | m1_AWVALID) begin
          // On a tie the master that did not hold the last grant wins.
          owner_n   = (m0_AWVALID & m1_AWVALID) ? ~w_owner : m1_AWVALID;
          state_n   = XFER;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
`ifdef AXI_ARB_W_TIMEOUT_EN
          cnt_n = '0;
`endif
        end
      end
      XFER: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | wl_hs;
        if (aw_done_n && w_done_n) begin
          state_n = RESP;
        end
`ifdef AXI_ARB_W_TIMEOUT_EN
        else if (!aw_done_n && !w_done_n) begin
          // Counter value is the number of XFER cycles already spent idle.
          if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            tmo_n   = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
`endif
      end
      RESP: begin
        if (b_hs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grants are decoded from the next state so they rise and fall with the state change.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      m0_wgrnt <= 1'b0;
      m1_wgrnt <= 1'b0;
      w_busy   <= 1'b0;
      w_owner  <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
`ifdef AXI_ARB_W_TIMEOUT_EN
      cnt       <= '0;
      w_timeout <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      w_owner  <= owner_n;
      m0_wgrnt <= (state_n != IDLE) && !owner_n;
      m1_wgrnt <= (state_n != IDLE) && owner_n;
      w_busy   <= (state_n != IDLE);
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
`ifdef AXI_ARB_W_TIMEOUT_EN
      cnt       <= cnt_n;
      w_timeout <= tmo_n;
`endif
    end
  end

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Scoreboard bench for axi_arbiter_w: stimulus pushes expected output changes, a monitor compares them.
module tb_axi_arbiter_w;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic m0_AWVALID, m1_AWVALID;
  logic s_AWVALID, s_WVALID, s_WLAST, s_BREADY;
  logic m_AWREADY, m_WREADY, m_BVALID;
  logic m0_wgrnt, m1_wgrnt, w_busy, w_owner;
  logic w_timeout;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  exp_t sb[$];

  axi_arbiter_w #(.TIMEOUT_CYCLES(4)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .m0_AWVALID (m0_AWVALID),
    .m1_AWVALID (m1_AWVALID),
    .s_AWVALID  (s_AWVALID),
    .s_WVALID   (s_WVALID),
    .s_WLAST    (s_WLAST),
    .s_BREADY   (s_BREADY),
    .m_AWREADY  (m_AWREADY),
    .m_WREADY   (m_WREADY),
    .m_BVALID   (m_BVALID),
    .m0_wgrnt   (m0_wgrnt),
    .m1_wgrnt   (m1_wgrnt),
    .w_busy     (w_busy),
`ifdef AXI_ARB_W_TIMEOUT_EN
    .w_owner    (w_owner),
    .w_timeout  (w_timeout)
`else
    .w_owner    (w_owner)
`endif
  );

`ifndef AXI_ARB_W_TIMEOUT_EN
  assign w_timeout = 1'b0;
`endif

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pushExp(input int c, input logic g0, input logic g1, input logic busy,
                         input logic owner, input logic tmo);
    exp_t e;
    e.cyc = c;
    e.vec = {g0, g1, busy, owner, tmo};
    sb.push_back(e);
  endtask

  task automatic idleBus();
    s_AWVALID = 1'b0;
    s_WVALID  = 1'b0;
    s_WLAST   = 1'b0;
    s_BREADY  = 1'b0;
    m_AWREADY = 1'b0;
    m_WREADY  = 1'b0;
    m_BVALID  = 1'b0;
  endtask

  // Called in an IDLE cycle: requests are sampled at the next edge and the whole
  // transaction is played with offsets k counted from the first granted cycle.
  task automatic applyStimulus(input logic r0, input logic r1, input logic expm,
                               input int aw_off, input int wl_off, input int beats,
                               input int b_stall, input logic bnoise, input logic hold_req);
    int c, done_k, b_k;
    c      = cyc;
    done_k = (aw_off > wl_off) ? aw_off : wl_off;
    b_k    = done_k + 1 + b_stall;
    m0_AWVALID = r0;
    m1_AWVALID = r1;
    pushExp(c + 1, !expm, expm, 1'b1, expm, 1'b0);
    pushExp(c + 2 + b_k, 1'b0, 1'b0, 1'b0, expm, 1'b0);
    tick();
    for (int k = 0; k <= b_k; k++) begin
      s_AWVALID = (k <= aw_off);
      m_AWREADY = (k == aw_off);
      s_WVALID  = (k <= wl_off) && (k > wl_off - beats);
      s_WLAST   = (k == wl_off);
      m_WREADY  = 1'b1;
      if (k > done_k) begin
        m_BVALID = 1'b1;
        s_BREADY = (k == b_k);
      end else begin
        m_BVALID = bnoise;
        s_BREADY = bnoise;
      end
      if (!hold_req && k > aw_off) begin
        m0_AWVALID = 1'b0;
        m1_AWVALID = 1'b0;
      end
      tick();
    end
    idleBus();
    if (!hold_req) begin
      m0_AWVALID = 1'b0;
      m1_AWVALID = 1'b0;
    end
  endtask

  // Monitor: each change of the output vector must match the next scoreboard entry.
  logic [4:0] prev_vec = 'x;
  always @(negedge ACLK) begin
    logic [4:0] v;
    exp_t e;
    v = {m0_wgrnt, m1_wgrnt, w_busy, w_owner, w_timeout};
    if (!$isunknown(v)) begin
      checkOutput("grant_exclusive", 32'(m0_wgrnt & m1_wgrnt), 32'd0);
      checkOutput("busy_vs_grant", 32'(w_busy), 32'(m0_wgrnt | m1_wgrnt));
    end
    if (v !== prev_vec) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_change at cycle %0d: got %b, want no change", cyc, v);
      end else begin
        e = sb.pop_front();
        checkOutput("out_vec", 32'(v), 32'(e.vec));
        checkOutput("out_cycle", cyc, e.cyc);
      end
      prev_vec = v;
    end
  end

  initial begin
    int c;
    ARESETn    = 1'b0;
    m0_AWVALID = 1'b0;
    m1_AWVALID = 1'b0;
    idleBus();
    pushExp(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    ARESETn = 1'b1;

    $display("[TB] single master 0, 4-beat write");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 3, 4, 0, 1'b0, 1'b0);

    $display("[TB] both masters requesting continuously");
    applyStimulus(1'b1, 1'b1, 1'b1, 0, 0, 1, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 0, 0, 1, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 1'b0, 1'b0);

    $display("[TB] master 1, WLAST before AW, stray BVALID in XFER");
    applyStimulus(1'b0, 1'b1, 1'b1, 3, 0, 1, 0, 1'b1, 1'b0);

    $display("[TB] B stalled for 10 cycles");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1, 10, 1'b0, 1'b0);

    $display("[TB] reset during RESP");
    c = cyc;
    m0_AWVALID = 1'b1;
    pushExp(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    s_AWVALID = 1'b1; m_AWREADY = 1'b1;
    s_WVALID  = 1'b1; s_WLAST   = 1'b1; m_WREADY = 1'b1;
    m0_AWVALID = 1'b0;
    tick();
    idleBus();
    m_BVALID = 1'b1;
    ARESETn  = 1'b0;
    pushExp(c + 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    ARESETn = 1'b1;
    idleBus();

    $display("[TB] tie after reset goes to master 0");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 1'b0, 1'b0);

`ifdef AXI_ARB_W_TIMEOUT_EN
    $display("[TB] AW timeout on master 0, master 1 next");
    c = cyc;
    m0_AWVALID = 1'b1;
    pushExp(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pushExp(c + 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    m0_AWVALID = 1'b0;
    m1_AWVALID = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 0, 1, 0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 4; i++) tick();
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
